// File: rtl/hex_scroll_ctrl.sv
// hex_scroll_ctrl: message buffer plus a 6-character window scrolled across
// HEX5..HEX0 at a programmable rate.
//
// Configuration macro: SCROLL_BIDIR_EN
//   defined   -> dir selects left (0) or right (1) scrolling
//   undefined -> dir is ignored, only left scrolling is built
//
// Write port protocol: wr_en is a plain strobe with no back-pressure; the
// character on wr_data is stored at wr_addr on every clock edge where wr_en
// is high, in any state. Displayed characters change only when refetched.
module hex_scroll_ctrl #(
  parameter int MAX_LEN = 32,
  parameter int AW      = 5,
  parameter int CW      = 32
) (
  input  logic          CLOCK_50,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [6:0]    wr_data,
  input  logic [AW:0]   msg_len,
  input  logic [CW-1:0] delay,
  input  logic          start,
  input  logic          pause,
  input  logic          dir,
  output logic [6:0]    HEX5,
  output logic [6:0]    HEX4,
  output logic [6:0]    HEX3,
  output logic [6:0]    HEX2,
  output logic [6:0]    HEX1,
  output logic [6:0]    HEX0,
  output logic          busy,
  output logic          wrap_pulse,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_RUN    = 2'd2,
    S_PAUSED = 2'd3
  } state_t;

  state_t        state_q, state_d;

  logic [6:0]    msg_buf [MAX_LEN];
  logic [6:0]    win_q   [6];

  logic [AW:0]   len_q;
  logic [CW-1:0] delay_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] head_q, tail_q;
  logic [AW-1:0] fill_ptr_q;
  logic [2:0]    fill_cnt_q;
  logic          wrap_q;

  // control strobes produced by the FSM and consumed by the datapath
  logic          do_load, do_stop, do_fill, do_count, do_shift;

  // modulo-len_q pointer helpers (compare-and-wrap, no division)
  logic [AW:0]   len_in;
  logic [AW-1:0] len_m1;
  logic [AW-1:0] fill_ptr_inc;
  logic [AW-1:0] head_inc, tail_inc;
  logic [AW-1:0] head_next, tail_next;
  logic [6:0]    new_char;
  logic          shift_right;

  // lengths above the buffer depth are clamped to the buffer depth
  assign len_in       = (msg_len > (AW+1)'(MAX_LEN)) ? (AW+1)'(MAX_LEN) : msg_len;
  assign len_m1       = AW'(len_q - (AW+1)'(1));
  assign fill_ptr_inc = (fill_ptr_q == len_m1) ? '0 : fill_ptr_q + AW'(1);
  assign head_inc     = (head_q == len_m1) ? '0 : head_q + AW'(1);
  assign tail_inc     = (tail_q == len_m1) ? '0 : tail_q + AW'(1);

`ifdef SCROLL_BIDIR_EN
  logic [AW-1:0] head_dec, tail_dec;

  assign head_dec    = (head_q == '0) ? len_m1 : head_q - AW'(1);
  assign tail_dec    = (tail_q == '0) ? len_m1 : tail_q - AW'(1);
  assign shift_right = dir;
  assign head_next   = dir ? head_dec : head_inc;
  assign tail_next   = dir ? tail_dec : tail_inc;
  assign new_char    = dir ? msg_buf[head_dec] : msg_buf[tail_inc];
`else
  logic unused_dir;

  assign unused_dir  = dir;
  assign shift_right = 1'b0;
  assign head_next   = head_inc;
  assign tail_next   = tail_inc;
  assign new_char    = msg_buf[tail_inc];
`endif

  // message buffer: synchronous write, never reset
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) begin
      msg_buf[wr_addr] <= wr_data;
    end
  end

  // FSM state register
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and datapath strobes; start outranks pause and shifts
  always_comb begin
    state_d  = state_q;
    do_load  = 1'b0;
    do_stop  = 1'b0;
    do_fill  = 1'b0;
    do_count = 1'b0;
    do_shift = 1'b0;
    if (start) begin
      if (len_in == '0) begin
        do_stop = 1'b1;
        state_d = S_IDLE;
      end else begin
        do_load = 1'b1;
        state_d = S_FILL;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_FILL: begin
          do_fill = 1'b1;
          if (fill_cnt_q == 3'd5) begin
            state_d = S_RUN;
          end
        end
        S_RUN, S_PAUSED: begin
          // pause freezes the count; a terminal count under pause waits
          // for release, and the release cycle itself counts/shifts
          if (pause) begin
            state_d = S_PAUSED;
          end else begin
            state_d = S_RUN;
            if (count_q == delay_q) begin
              do_shift = 1'b1;
            end else begin
              do_count = 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // window, pointers, tick counter and wrap pulse
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 6; k++) begin
        win_q[k] <= '0;
      end
      len_q      <= '0;
      delay_q    <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fill_ptr_q <= '0;
      fill_cnt_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (do_load) begin
        len_q      <= len_in;
        delay_q    <= delay;
        fill_ptr_q <= '0;
        fill_cnt_q <= '0;
        count_q    <= '0;
      end else if (do_stop) begin
        // an empty message blanks the display and stops
        for (int k = 0; k < 6; k++) begin
          win_q[k] <= '0;
        end
        count_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
      end else if (do_fill) begin
        win_q[3'd5 - fill_cnt_q] <= msg_buf[fill_ptr_q];
        fill_ptr_q               <= fill_ptr_inc;
        fill_cnt_q               <= fill_cnt_q + 3'd1;
        if (fill_cnt_q == 3'd5) begin
          // the last fetched index is what HEX0 shows
          head_q  <= '0;
          tail_q  <= fill_ptr_q;
          count_q <= '0;
        end
      end else if (do_count) begin
        count_q <= count_q + CW'(1);
      end else if (do_shift) begin
        count_q <= '0;
        if (shift_right) begin
          for (int k = 0; k < 5; k++) begin
            win_q[k] <= win_q[k+1];
          end
          win_q[5] <= new_char;
        end else begin
          for (int k = 5; k > 0; k--) begin
            win_q[k] <= win_q[k-1];
          end
          win_q[0] <= new_char;
        end
        head_q <= head_next;
        tail_q <= tail_next;
        if (head_next == '0) begin
          wrap_q  <= 1'b1;
          delay_q <= delay;
        end
      end
    end
  end

  // active-low segment drive; an all-zero window reads as blank
  assign HEX5       = ~win_q[5];
  assign HEX4       = ~win_q[4];
  assign HEX3       = ~win_q[3];
  assign HEX2       = ~win_q[2];
  assign HEX1       = ~win_q[1];
  assign HEX0       = ~win_q[0];
  assign busy       = (state_q != S_IDLE);
  assign wrap_pulse = wrap_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Testbench for hex_scroll_ctrl: directed scenarios plus randomized runs
// checked against an index-based reference model of the scrolling display.
module tb_hex_scroll_ctrl;

  localparam int MAX_LEN = 32;
  localparam int AW      = 5;
  localparam int CW      = 32;

  localparam logic [41:0] BLANK      = {6{7'h7F}};
  localparam logic [41:0] HELLO_FILL = ~{7'h76, 7'h79, 7'h38, 7'h38, 7'h3F, 7'h76};
  localparam logic [41:0] SHIFT1     = ~{7'h79, 7'h38, 7'h38, 7'h3F, 7'h76, 7'h79};
  localparam logic [41:0] SHIFT2     = ~{7'h38, 7'h38, 7'h3F, 7'h76, 7'h79, 7'h38};

  logic          CLOCK_50 = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [6:0]    wr_data;
  logic [AW:0]   msg_len;
  logic [CW-1:0] delay;
  logic          start;
  logic          pause;
  logic          dir;
  logic [6:0]    HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;
  logic          busy;
  logic          wrap_pulse;
  logic [1:0]    state_dbg;
  logic [41:0]   hex_all;

  int vectors     = 0;
  int miscompares = 0;

  // reference model: window described by the head index into the message
  logic [6:0] mem [MAX_LEN];
  bit         m_active;
  int         m_fill_left;
  int         m_len;
  int         m_head;
  int         m_count;
  int         m_delay;
  bit         m_wrap;

  assign hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  // clock / reset
  always #5 CLOCK_50 = ~CLOCK_50;

  hex_scroll_ctrl #(.MAX_LEN(MAX_LEN), .AW(AW), .CW(CW)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .msg_len   (msg_len),
    .delay     (delay),
    .start     (start),
    .pause     (pause),
    .dir       (dir),
    .HEX5      (HEX5),
    .HEX4      (HEX4),
    .HEX3      (HEX3),
    .HEX2      (HEX2),
    .HEX1      (HEX1),
    .HEX0      (HEX0),
    .busy      (busy),
    .wrap_pulse(wrap_pulse),
    .state_dbg (state_dbg)
  );

  task automatic model_reset();
    m_active    = 1'b0;
    m_fill_left = 0;
    m_len       = 1;
    m_head      = 0;
    m_count     = 0;
    m_delay     = 0;
    m_wrap      = 1'b0;
  endtask

  // one clock edge of behaviour, using the inputs currently applied
  task automatic model_edge();
    bit right;
`ifdef SCROLL_BIDIR_EN
    right = dir;
`else
    right = 1'b0;
`endif
    m_wrap = 1'b0;
    if (!reset_n) begin
      model_reset();
    end else begin
      if (start) begin
        if (msg_len == 0) begin
          m_active = 1'b0;
        end else begin
          m_active    = 1'b1;
          m_len       = (int'(msg_len) > MAX_LEN) ? MAX_LEN : int'(msg_len);
          m_delay     = int'(delay);
          m_fill_left = 6;
          m_count     = 0;
        end
      end else if (m_active && m_fill_left > 0) begin
        m_fill_left--;
        if (m_fill_left == 0) begin
          m_head  = 0;
          m_count = 0;
        end
      end else if (m_active && !pause) begin
        if (m_count == m_delay) begin
          m_count = 0;
          m_head  = right ? (m_head + m_len - 1) % m_len : (m_head + 1) % m_len;
          if (m_head == 0) begin
            m_wrap  = 1'b1;
            m_delay = int'(delay);
          end
        end else begin
          m_count++;
        end
      end
      if (wr_en) mem[wr_addr] = wr_data;
    end
  endtask

  // HEX5 shows mem[head], HEXk shows mem[head + 5 - k]
  function automatic logic [41:0] exp_hex();
    logic [41:0] r;
    if (!m_active) return BLANK;
    for (int k = 0; k < 6; k++) begin
      r[k*7 +: 7] = ~mem[(m_head + 5 - k) % m_len];
    end
    return r;
  endfunction

  // driver tasks: inputs change at the falling edge, outputs checked there
  task automatic step();
    model_edge();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    pause   = 1'b0;
    dir     = 1'b0;
    msg_len = '0;
    delay   = '0;
    model_reset();
    repeat (2) @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic write_char(input int addr, input logic [6:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start(input int len, input int dly);
    msg_len = (AW+1)'(len);
    delay   = CW'(dly);
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (hex_all !== BLANK) begin
      miscompares++;
      $display("FAIL reset_hex: got %h expected %h", hex_all, BLANK);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    vectors++;
    if (wrap_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wrap: got %b expected 0", wrap_pulse);
    end
  endtask

  task automatic test_hello();
    write_char(0, 7'h76);
    write_char(1, 7'h79);
    write_char(2, 7'h38);
    write_char(3, 7'h38);
    write_char(4, 7'h3F);
    pulse_start(5, 3);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL hello_busy: got %b expected 1", busy);
    end
    repeat (6) step();
    vectors++;
    if (hex_all !== HELLO_FILL) begin
      miscompares++;
      $display("FAIL hello_fill: got %h expected %h", hex_all, HELLO_FILL);
    end
    vectors++;
    if (hex_all !== exp_hex()) begin
      miscompares++;
      $display("FAIL hello_fill_model: got %h expected %h", hex_all, exp_hex());
    end
    repeat (3) step();
    vectors++;
    if (hex_all !== HELLO_FILL) begin
      miscompares++;
      $display("FAIL hello_early_shift: got %h expected %h", hex_all, HELLO_FILL);
    end
    step();
    vectors++;
    if (hex_all !== SHIFT1) begin
      miscompares++;
      $display("FAIL hello_shift1: got %h expected %h", hex_all, SHIFT1);
    end
  endtask

  task automatic test_wrap();
    int  n    = 0;
    bit  seen = 1'b0;
    delay = CW'(1);
    while (!seen && n < 40) begin
      step();
      n++;
      vectors++;
      if (hex_all !== exp_hex()) begin
        miscompares++;
        $display("FAIL wrap_hex: got %h expected %h", hex_all, exp_hex());
      end
      vectors++;
      if (wrap_pulse !== m_wrap) begin
        miscompares++;
        $display("FAIL wrap_pulse: got %b expected %b", wrap_pulse, m_wrap);
      end
      if (wrap_pulse === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (n != 16) begin
      miscompares++;
      $display("FAIL wrap_latency: got %0d cycles expected 16", n);
    end
    vectors++;
    if (hex_all !== HELLO_FILL) begin
      miscompares++;
      $display("FAIL wrap_window: got %h expected %h", hex_all, HELLO_FILL);
    end
    step();
    vectors++;
    if (wrap_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_one_cycle: got %b expected 0", wrap_pulse);
    end
    vectors++;
    if (hex_all !== HELLO_FILL) begin
      miscompares++;
      $display("FAIL wrap_new_delay_early: got %h expected %h", hex_all, HELLO_FILL);
    end
    step();
    vectors++;
    if (hex_all !== SHIFT1) begin
      miscompares++;
      $display("FAIL wrap_new_delay: got %h expected %h", hex_all, SHIFT1);
    end
  endtask

  task automatic test_pause();
    pulse_start(5, 3);
    repeat (6) step();
    repeat (2) step();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (hex_all !== HELLO_FILL) begin
        miscompares++;
        $display("FAIL pause_hold: got %h expected %h", hex_all, HELLO_FILL);
      end
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pause_busy: got %b expected 1", busy);
    end
    pause = 1'b0;
    step();
    vectors++;
    if (hex_all !== HELLO_FILL) begin
      miscompares++;
      $display("FAIL pause_resume_early: got %h expected %h", hex_all, HELLO_FILL);
    end
    step();
    vectors++;
    if (hex_all !== SHIFT1) begin
      miscompares++;
      $display("FAIL pause_resume_shift: got %h expected %h", hex_all, SHIFT1);
    end
    // pause raised exactly at the terminal count
    repeat (3) step();
    pause = 1'b1;
    repeat (5) step();
    vectors++;
    if (hex_all !== SHIFT1) begin
      miscompares++;
      $display("FAIL pause_terminal_hold: got %h expected %h", hex_all, SHIFT1);
    end
    pause = 1'b0;
    step();
    vectors++;
    if (hex_all !== SHIFT2) begin
      miscompares++;
      $display("FAIL pause_terminal_resume: got %h expected %h", hex_all, SHIFT2);
    end
  endtask

  task automatic test_start_terminal();
    repeat (3) step();
    pulse_start(5, 3);
    vectors++;
    if (hex_all !== SHIFT2) begin
      miscompares++;
      $display("FAIL start_no_shift: got %h expected %h", hex_all, SHIFT2);
    end
    vectors++;
    if (wrap_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL start_no_wrap: got %b expected 0", wrap_pulse);
    end
    repeat (6) step();
    vectors++;
    if (hex_all !== HELLO_FILL) begin
      miscompares++;
      $display("FAIL start_refill: got %h expected %h", hex_all, HELLO_FILL);
    end
    repeat (4) step();
    vectors++;
    if (hex_all !== SHIFT1) begin
      miscompares++;
      $display("FAIL start_count_reset: got %h expected %h", hex_all, SHIFT1);
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    pulse_start(0, 2);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_len_busy: got %b expected 0", busy);
      end
      vectors++;
      if (hex_all !== BLANK) begin
        miscompares++;
        $display("FAIL zero_len_hex: got %h expected %h", hex_all, BLANK);
      end
      step();
    end
  endtask

  task automatic test_dir();
    logic [6:0] exp5;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      write_char(i, 7'($urandom_range(0, 127)));
    end
    dir = 1'b1;
    pulse_start(8, 2);
    repeat (6) step();
    vectors++;
    if (hex_all !== exp_hex()) begin
      miscompares++;
      $display("FAIL dir_fill: got %h expected %h", hex_all, exp_hex());
    end
    repeat (3) step();
`ifdef SCROLL_BIDIR_EN
    exp5 = ~mem[7];
`else
    exp5 = ~mem[1];
`endif
    vectors++;
    if (HEX5 !== exp5) begin
      miscompares++;
      $display("FAIL dir_first_shift: got %h expected %h", HEX5, exp5);
    end
    vectors++;
    if (hex_all !== exp_hex()) begin
      miscompares++;
      $display("FAIL dir_window: got %h expected %h", hex_all, exp_hex());
    end
    dir = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    repeat (5) step();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (hex_all !== BLANK) begin
      miscompares++;
      $display("FAIL async_reset_hex: got %h expected %h", hex_all, BLANK);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_busy: got %b expected 0", busy);
    end
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    step();
    vectors++;
    if (hex_all !== BLANK || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset: got hex %h busy %b expected %h busy 0", hex_all, busy, BLANK);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < MAX_LEN; i++) begin
      write_char(i, 7'($urandom_range(0, 127)));
    end
    for (int s = 0; s < 5; s++) begin
      dir = 1'($urandom_range(0, 1));
      pulse_start($urandom_range(1, MAX_LEN), $urandom_range(0, 3));
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 7) == 0) pause = ~pause;
        if ($urandom_range(0, 49) == 0) dir = ~dir;
        if ($urandom_range(0, 79) == 0) begin
          start   = 1'b1;
          msg_len = ($urandom_range(0, 9) == 0) ? '0 : (AW+1)'($urandom_range(1, MAX_LEN));
          delay   = CW'($urandom_range(0, 3));
        end else if ($urandom_range(0, 9) == 0) begin
          delay = CW'($urandom_range(0, 3));
        end
        step();
        start = 1'b0;
        vectors++;
        if (busy !== m_active) begin
          miscompares++;
          $display("FAIL rand_busy: got %b expected %b", busy, m_active);
        end
        vectors++;
        if (wrap_pulse !== m_wrap) begin
          miscompares++;
          $display("FAIL rand_wrap: got %b expected %b", wrap_pulse, m_wrap);
        end
        if (m_fill_left == 0) begin
          vectors++;
          if (hex_all !== exp_hex()) begin
            miscompares++;
            $display("FAIL rand_hex: got %h expected %h", hex_all, exp_hex());
          end
        end
      end
      pause = 1'b0;
    end
  endtask

  // watchdog: the run must never hang
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_hello();
    test_wrap();
    test_pause();
    test_start_terminal();
    test_zero_len();
    test_dir();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hex_scroll_ctrl.md
Name: hex_scroll_ctrl

Overview:
- Sequencer for the six seven-segment displays: holds a message of segment codes and scrolls a 6-character window across HEX5..HEX0 at a rate set by a delay word.
- The delay word comes from the HPS PIO.
- Sits between the Qsys system (delay, message writes, pushbuttons) and the HEX pins, replacing ad hoc scroll logic in the top level.

Parameters:
- MAX_LEN, 32, message buffer depth in characters (power of two, ≥ 6).
- AW, 5, buffer address width, equal to log2(MAX_LEN).
- CW, 32, delay/counter width.

Ports:
- CLOCK_50  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  message write strobe.
- wr_addr  in  AW  message write address.
- wr_data  in  7  segment code, active-high, bit0 = seg a.
- msg_len  in  AW+1  message length, valid 0..MAX_LEN; sampled on start.
- delay  in  CW  ticks between shifts minus one.
- start  in  1  one-cycle pulse, (re)starts scrolling from char 0.
- pause  in  1  level; freezes scrolling while high.
- dir  in  1  0 = scroll left (text moves toward HEX5), 1 = right.
- HEX5..HEX0  out  7 each  active-low segments; HEX5 is the leftmost display.
- busy  out  1  high in FILL/RUN/PAUSED.
- wrap_pulse  out  1  one-cycle pulse when the window head returns to char 0.

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - State IDLE; HEX* = 7'h7F (blank); busy = 0, wrap_pulse = 0.
  - head, tail and count = 0.
  - Buffer contents are not reset.
- Buffer: MAX_LEN x 7 register array; synchronous write on wr_en; combinational read. Writes are accepted in every state; a written char is displayed when it is next fetched.
- Window: six registers win[5..0]; HEXk = ~win[k]. head = index shown on HEX5, tail = index shown on HEX0. All index arithmetic is modulo len_q.
- States:
  - IDLE: on start with msg_len = 0, stay IDLE. On start with msg_len > 0: len_q <= msg_len, delay_q <= delay, fill_idx <= 0, go to FILL.
  - FILL: 6 cycles. Cycle i loads win[5-i] <= buf[i mod len_q]. After the 6th cycle: head = 0, tail = 5 mod len_q, count = 0, go to RUN. Messages with len_q < 6 repeat within the window.
  - RUN: count increments each cycle. When count == delay_q: count <= 0 and one shift occurs.
    - Shift left: win[5..1] <= win[4..0]; win[0] <= buf[(tail+1) mod len_q]; head++, tail++.
    - Shift right: win[4..0] <= win[5..1]; win[5] <= buf[(head-1) mod len_q]; head--, tail--.
    - Shift period is delay_q+1 cycles; delay_q = 0 shifts every cycle.
    - Any shift that makes the new head 0 asserts wrap_pulse for the following cycle and reloads delay_q <= delay.
    - If pause is high, go to PAUSED.
  - PAUSED: count, window and pointers hold. When pause falls, return to RUN and continue counting from the held count.
- Simultaneous events:
  - start in any state restarts: go to FILL with fresh len_q/delay_q; start has priority over pause and over a shift in the same cycle.
  - pause and a terminal count in the same cycle: the shift is suppressed and count holds at delay_q, so the shift fires on the first RUN cycle after resume.
  - reset_n mid-FILL/RUN forces the reset state immediately.
- Live changes: msg_len and delay changes take effect only at start (and, for delay, at wrap).
- Modulo handling: compare-and-wrap on increment/decrement only; no dividers. Pointer width is AW.

Optional Feature:
- SCROLL_BIDIR_EN
  - Defined: dir is honoured as above.
  - Undefined: dir is ignored, only left shift is synthesised, and the head-decrement logic is removed.

Test Plan:
- Reset, then load "HELLO" (76,79,38,38,3F) at 0..4 and msg_len = 5, delay = 3, start. Expected:
  - After 6 FILL cycles: HEX5..HEX0 = ~{76,79,38,38,3F,76}.
  - First shift exactly 4 cycles later: ~{79,38,38,3F,76,79}.
- Same message, 5 shifts left: wrap_pulse high for exactly one cycle after the 5th shift. Window then equals the post-FILL window; delay changed to 1 beforehand takes effect (next shift 2 cycles later).
- pause high at count = 2 for 10 cycles, then low: no shift during pause; shift occurs 2 cycles after release (count resumes at 2 → 3 → shift).
- start with msg_len = 0: state stays IDLE, busy = 0, HEX all 7'h7F.
- With SCROLL_BIDIR_EN and dir = 1, len 8: first shift gives HEX5 = ~buf[7]. With the macro undefined, dir = 1 still scrolls left.
- reset_n low mid-RUN: HEX = 7'h7F and busy = 0 asynchronously. A start pulse asserted together with a terminal count in RUN: the window refills from char 0 and no shift occurs.
